dbi_decode_16b: RTL

- Receive-side counterpart of the 16-bit DBI encoder.
- Accepts 17-bit encoded words {dbi_flag, payload} over a valid/ready handshake and restores the original data by conditionally inverting the payload.
- Buffers results in a 2-entry skid FIFO and, optionally, keeps bus-activity statistics.
- Sits between the encoded link and the systolic-array PE input.

---
 rtl/dbi_decode_16b_if.sv | 20 ++
 rtl/dbi_decode_16b.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dbi_decode_16b_if.sv
// Encoded-in / decoded-out stream bundle for dbi_decode_16b.
// master = link/PE side driving words in and taking results; slave = the decoder.
interface dbi_decode_16b_if #(parameter int bw = 16);
  logic [bw:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [bw-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/dbi_decode_16b.sv
// DBI receive decoder: conditional payload inversion into a 2-entry skid FIFO.
// Optional bus statistics are built only when DBI_DEC_STATS_EN is defined.
module dbi_decode_16b #(
  parameter int bw    = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dbi_en,
  input  logic                 stats_clr,
  dbi_decode_16b_if.slave      bus,
  output logic [CNT_W-1:0]     toggle_cnt,
  output logic [CNT_W-1:0]     inv_cnt,
  output logic [CNT_W-1:0]     word_cnt
);

  function automatic logic [bw-1:0] dbi_dec(input logic [bw:0] w, input logic en);
    return (en & w[bw]) ? ~w[bw-1:0] : w[bw-1:0];
  endfunction

  logic          accept, pop;
  logic [1:0]    count_q, count_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [bw-1:0] mem_q [2];
  logic [bw-1:0] mem_d [2];

  assign bus.in_ready  = (count_q != 2'd2) & ~reset;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign accept        = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;
    if (accept) begin
      mem_d[wr_ptr_q] = dbi_dec(bus.in_data, dbi_en);
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
    end
  end

`ifdef DBI_DEC_STATS_EN
  localparam int PC_W  = $clog2(bw + 2);
  // Sum wide enough for either operand so a popcount larger than the counter range still saturates.
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((64'd1 << CNT_W) - 64'd1);

  function automatic logic [PC_W-1:0] popcnt(input logic [bw:0] v);
    logic [PC_W-1:0] s;
    s = '0;
    for (int i = 0; i <= bw; i++) s = s + PC_W'(v[i]);
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [SUM_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + inc;
    return (s > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(s);
  endfunction

  logic [bw:0]      prev_enc_q, prev_enc_d;
  logic [CNT_W-1:0] toggle_q, toggle_d;
  logic [CNT_W-1:0] inv_q, inv_d;
  logic [CNT_W-1:0] word_q, word_d;

  always_comb begin
    prev_enc_d = prev_enc_q;
    toggle_d   = toggle_q;
    inv_d      = inv_q;
    word_d     = word_q;
    if (accept) prev_enc_d = bus.in_data;
    if (stats_clr) begin
      toggle_d = '0;
      inv_d    = '0;
      word_d   = '0;
    end else if (accept) begin
      toggle_d = sat_add(toggle_q, SUM_W'(popcnt(prev_enc_q ^ bus.in_data)));
      if (dbi_en & bus.in_data[bw]) inv_d = sat_add(inv_q, SUM_W'(1));
      word_d   = sat_add(word_q, SUM_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_enc_q <= '0;
      toggle_q   <= '0;
      inv_q      <= '0;
      word_q     <= '0;
    end else begin
      prev_enc_q <= prev_enc_d;
      toggle_q   <= toggle_d;
      inv_q      <= inv_d;
      word_q     <= word_d;
    end
  end

  assign toggle_cnt = toggle_q;
  assign inv_cnt    = inv_q;
  assign word_cnt   = word_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign toggle_cnt = '0;
  assign inv_cnt    = '0;
  assign word_cnt   = '0;
`endif

endmodule
